// File: rtl/fft_pkg.sv
// Shared constants, state encoding and index helpers for the FFT output streamer.
// FFT_OUT_BITREV_EN (consumers) selects bit-reversed bin order at the read mux.
package fft_pkg;
   localparam int N_FFT = 512;
   localparam int LANES = 16;
   localparam int BEATS = 32;

   function automatic int bin_w(input int width);
      return width + 4;
   endfunction

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } stream_state_e;

   function automatic logic [8:0] bitrev9(input logic [8:0] idx);
      logic [8:0] r;
      r = '0;
      for (int unsigned i = 0; i < 9; i++) begin
         r[i] = idx[8 - i];
      end
      return r;
   endfunction
endpackage

// File: rtl/fft_out_streamer_beat_mux.sv
// 32:1 beat selection from the frame buffer onto the 16 output lanes.
// With FFT_OUT_BITREV_EN defined, lanes read bin bitrev9(16*beat+lane).
module fft_beat_mux
   import fft_pkg::*;
#(
   parameter int BW = 13
) (
   input  logic signed [BW-1:0] buf_re  [0:N_FFT-1],
   input  logic signed [BW-1:0] buf_im  [0:N_FFT-1],
   input  logic        [4:0]    beat,
   output logic signed [BW-1:0] lane_re [0:LANES-1],
   output logic signed [BW-1:0] lane_im [0:LANES-1]
);
   always_comb begin
      for (int unsigned j = 0; j < LANES; j++) begin
         logic [8:0] idx;
         idx = {beat, 4'(j)};
`ifdef FFT_OUT_BITREV_EN
         idx = bitrev9(idx);
`endif
         lane_re[j] = buf_re[idx];
         lane_im[j] = buf_im[idx];
      end
   end
endmodule

// File: rtl/fft_out_streamer.sv
// Buffers one 512-bin FFT frame and streams it as 32 beats of 16 lanes with
// valid/ready handshaking; FFT_OUT_BITREV_EN selects bit-reversed lane order.
module fft_out_streamer
   import fft_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic signed [bin_w(WIDTH)-1:0]  din_re [0:N_FFT-1],
   input  logic signed [bin_w(WIDTH)-1:0]  din_im [0:N_FFT-1],
   input  logic                            din_en,
   output logic signed [bin_w(WIDTH)-1:0]  m_re   [0:LANES-1],
   output logic signed [bin_w(WIDTH)-1:0]  m_im   [0:LANES-1],
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic                            m_last,
   output logic        [4:0]               m_beat,
   output logic                            ovf,
   input  logic                            ovf_clr
);
   localparam int BW = bin_w(WIDTH);
   localparam logic [0:0] IDLE   = ST_IDLE;
   localparam logic [0:0] STREAM = ST_STREAM;

   logic [0:0]          state_q, state_d;
   logic [4:0]          beat_q, beat_d;
   logic                ovf_q, ovf_d;
   logic signed [BW-1:0] buf_re_q [0:N_FFT-1];
   logic signed [BW-1:0] buf_re_d [0:N_FFT-1];
   logic signed [BW-1:0] buf_im_q [0:N_FFT-1];
   logic signed [BW-1:0] buf_im_d [0:N_FFT-1];
   logic                hs, last_hs, capture, drop;

   always_comb begin
      hs       = (state_q == STREAM) && m_ready;
      last_hs  = hs && (beat_q == 5'(BEATS - 1));
      // A frame is accepted only when the buffer is free or being released this edge.
      capture  = din_en && ((state_q == IDLE) || last_hs);
      drop     = din_en && (state_q == STREAM) && !last_hs;
      state_d  = state_q;
      beat_d   = beat_q;
      buf_re_d = buf_re_q;
      buf_im_d = buf_im_q;
      if (capture) begin
         buf_re_d = din_re;
         buf_im_d = din_im;
         beat_d   = '0;
         state_d  = STREAM;
      end else if (last_hs) begin
         beat_d  = '0;
         state_d = IDLE;
      end else if (hs) begin
         beat_d = beat_q + 5'd1;
      end
      ovf_d = drop | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         ovf_q    <= 1'b0;
         buf_re_q <= '{default: '0};
         buf_im_q <= '{default: '0};
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         ovf_q    <= ovf_d;
         buf_re_q <= buf_re_d;
         buf_im_q <= buf_im_d;
      end
   end

   fft_beat_mux #(
      .BW (BW)
   ) u_beat_mux (
      .buf_re  (buf_re_q),
      .buf_im  (buf_im_q),
      .beat    (beat_q),
      .lane_re (m_re),
      .lane_im (m_im)
   );

   assign m_valid = (state_q == STREAM);
   assign m_beat  = beat_q;
   assign m_last  = m_valid && (beat_q == 5'(BEATS - 1));
   assign ovf     = ovf_q;
endmodule

// File: tb/tb_fft_out_streamer.sv
// Directed bench for fft_out_streamer: ramp, backpressure, back-to-back frames,
// dropped-frame flag and mid-frame reset; honours FFT_OUT_BITREV_EN.
module tb_fft_out_streamer;
   localparam int WIDTH = 9;
   localparam int BW    = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rstn, din_en, m_ready, ovf_clr;
   logic signed [BW-1:0] din_re [0:511];
   logic signed [BW-1:0] din_im [0:511];
   logic signed [BW-1:0] m_re   [0:15];
   logic signed [BW-1:0] m_im   [0:15];
   logic                 m_valid, m_last, ovf;
   logic [4:0]           m_beat;

   fft_out_streamer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rstn(rstn), .din_re(din_re), .din_im(din_im), .din_en(din_en),
      .m_re(m_re), .m_im(m_im), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .m_beat(m_beat), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   typedef struct {
      int beat;
      int lane;
      int re;
      int im;
      bit last;
   } vec_t;

   vec_t vecs [0:6];
   int   checks = 0;
   int   errors = 0;
   int   got_re [0:511];
   int   got_im [0:511];
   int   got_last [0:31];
   int   got_beat [0:31];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int fr_re(input int kind, input int n);
      case (kind)
         0: return n;
         1: return 1000 - n;
         2: return n + 100;
         default: return 77;
      endcase
   endfunction

   function automatic int fr_im(input int kind, input int n);
      case (kind)
         0: return -n;
         1: return n - 1000;
         2: return -(n + 100);
         default: return -77;
      endcase
   endfunction

   function automatic int exp_idx(input int k, input int j);
      int n;
      n = 16 * k + j;
`ifdef FFT_OUT_BITREV_EN
      begin
         int r;
         r = 0;
         for (int b = 0; b < 9; b++) if ((n >> b) & 1) r = r | (1 << (8 - b));
         return r;
      end
`else
      return n;
`endif
   endfunction

   task automatic load_frame(input int kind);
      for (int n = 0; n < 512; n++) begin
         din_re[n] = 13'(fr_re(kind, n));
         din_im[n] = 13'(fr_im(kind, n));
      end
   endtask

   // Called at a negedge; leaves the bench at the negedge after the edge that captured.
   task automatic start_frame(input int kind);
      load_frame(kind);
      din_en = 1'b1;
      @(negedge clk);
      din_en = 1'b0;
      chk("latency_valid", int'(m_valid), 1);
      chk("latency_beat", int'(m_beat), 0);
   endtask

   // Collect n handshaken beats; bp selects the 1,0,0,1 ready pattern.
   task automatic run_beats(input int n, input bit bp);
      int got, cyc, ph;
      bit prev_stall;
      int s_re0, s_re15, s_im0, s_last, s_beat;
      got = 0; cyc = 0; ph = 0; prev_stall = 1'b0;
      s_re0 = 0; s_re15 = 0; s_im0 = 0; s_last = 0; s_beat = 0;
      while (got < n && cyc < 400) begin
         m_ready = bp ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
         ph++;
         if (prev_stall) begin
            chk("stall_re0", int'(m_re[0]), s_re0);
            chk("stall_re15", int'(m_re[15]), s_re15);
            chk("stall_im0", int'(m_im[0]), s_im0);
            chk("stall_last", int'(m_last), s_last);
            chk("stall_beat", int'(m_beat), s_beat);
         end
         prev_stall = m_valid && !m_ready;
         s_re0 = int'(m_re[0]); s_re15 = int'(m_re[15]); s_im0 = int'(m_im[0]);
         s_last = int'(m_last); s_beat = int'(m_beat);
         if (m_valid && m_ready) begin
            for (int j = 0; j < 16; j++) begin
               got_re[got * 16 + j] = int'(m_re[j]);
               got_im[got * 16 + j] = int'(m_im[j]);
            end
            got_last[got] = int'(m_last);
            got_beat[got] = int'(m_beat);
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      if (got < n) chk("beat_timeout", got, n);
   endtask

   task automatic verify_frame(input string tag, input int kind, input int off, input int n);
      for (int k = 0; k < n; k++) begin
         chk({tag, "_beat"}, got_beat[k], k + off);
         chk({tag, "_last"}, got_last[k], (k + off == 31) ? 1 : 0);
         for (int j = 0; j < 16; j++) begin
            chk({tag, "_re"}, got_re[k * 16 + j], fr_re(kind, exp_idx(k + off, j)));
            chk({tag, "_im"}, got_im[k * 16 + j], fr_im(kind, exp_idx(k + off, j)));
         end
      end
   endtask

   initial begin
`ifdef FFT_OUT_BITREV_EN
      vecs[0] = '{0, 1, 256, -256, 1'b0};
      vecs[1] = '{1, 0, 16, -16, 1'b0};
      vecs[2] = '{16, 0, 1, -1, 1'b0};
      vecs[3] = '{0, 0, 0, 0, 1'b0};
      vecs[4] = '{0, 2, 128, -128, 1'b0};
      vecs[5] = '{31, 0, 31, -31, 1'b1};
      vecs[6] = '{31, 15, 511, -511, 1'b1};
`else
      vecs[0] = '{0, 0, 0, 0, 1'b0};
      vecs[1] = '{0, 15, 15, -15, 1'b0};
      vecs[2] = '{1, 0, 16, -16, 1'b0};
      vecs[3] = '{10, 3, 163, -163, 1'b0};
      vecs[4] = '{30, 15, 495, -495, 1'b0};
      vecs[5] = '{31, 0, 496, -496, 1'b1};
      vecs[6] = '{31, 15, 511, -511, 1'b1};
`endif
      rstn = 1'b0; din_en = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
      load_frame(0);
      #1;
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_last", int'(m_last), 0);
      chk("rst_beat", int'(m_beat), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_re7", int'(m_re[7]), 0);
      chk("rst_im7", int'(m_im[7]), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Ramp frame, full throughput
      start_frame(0);
      run_beats(32, 1'b0);
      chk("ramp_end_valid", int'(m_valid), 0);
      chk("ramp_end_last", int'(m_last), 0);
      for (int i = 0; i < 7; i++) begin
         chk("vec_re", got_re[vecs[i].beat * 16 + vecs[i].lane], vecs[i].re);
         chk("vec_im", got_im[vecs[i].beat * 16 + vecs[i].lane], vecs[i].im);
         chk("vec_last", got_last[vecs[i].beat], int'(vecs[i].last));
      end
      verify_frame("ramp", 0, 0, 32);

      // Backpressure 1,0,0,1
      start_frame(0);
      run_beats(32, 1'b1);
      verify_frame("bp", 0, 0, 32);
      chk("bp_end_valid", int'(m_valid), 0);

      // Back-to-back frames with capture on the beat-31 handshake
      start_frame(0);
      run_beats(31, 1'b0);
      chk("b2b_last", int'(m_last), 1);
      chk("b2b_beat31", int'(m_beat), 31);
      chk("b2b_re31", int'(m_re[15]), fr_re(0, exp_idx(31, 15)));
      load_frame(1);
      din_en = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      din_en = 1'b0;
      chk("b2b_valid", int'(m_valid), 1);
      chk("b2b_beat0", int'(m_beat), 0);
      chk("b2b_re0", int'(m_re[0]), fr_re(1, exp_idx(0, 0)));
      run_beats(32, 1'b0);
      verify_frame("b2b", 1, 0, 32);
      chk("b2b_end_valid", int'(m_valid), 0);
      chk("b2b_ovf", int'(ovf), 0);

      // Dropped frame at beat 10
      start_frame(0);
      run_beats(10, 1'b0);
      load_frame(3);
      din_en = 1'b1; m_ready = 1'b0;
      @(negedge clk);
      din_en = 1'b0;
      chk("drop_ovf", int'(ovf), 1);
      chk("drop_beat", int'(m_beat), 10);
      chk("drop_re0", int'(m_re[0]), fr_re(0, exp_idx(10, 0)));
      run_beats(22, 1'b0);
      verify_frame("drop", 0, 10, 22);
      chk("drop_end_valid", int'(m_valid), 0);
      chk("drop_ovf_sticky", int'(ovf), 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_clr", int'(ovf), 0);

      // Set wins over clear
      start_frame(0);
      m_ready = 1'b0;
      load_frame(3);
      din_en = 1'b1;
      @(negedge clk);
      chk("drop2_ovf", int'(ovf), 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      din_en = 1'b0;
      chk("set_wins", int'(ovf), 1);
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("clr_alone", int'(ovf), 0);
      chk("drop2_beat", int'(m_beat), 0);
      run_beats(32, 1'b0);
      verify_frame("keep", 0, 0, 32);

      // Reset mid-frame at beat 5 (ovf set beforehand)
      start_frame(0);
      run_beats(4, 1'b0);
      load_frame(3);
      din_en = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      din_en = 1'b0; m_ready = 1'b0;
      chk("pre_rst_ovf", int'(ovf), 1);
      chk("pre_rst_beat", int'(m_beat), 5);
      chk("pre_rst_re0", int'(m_re[0]), fr_re(0, exp_idx(5, 0)));
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_valid", int'(m_valid), 0);
      chk("mid_rst_beat", int'(m_beat), 0);
      chk("mid_rst_last", int'(m_last), 0);
      chk("mid_rst_ovf", int'(ovf), 0);
      chk("mid_rst_re3", int'(m_re[3]), 0);
      chk("mid_rst_im3", int'(m_im[3]), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", int'(m_valid), 0);
      start_frame(2);
      run_beats(32, 1'b0);
      verify_frame("post_rst", 2, 0, 32);
      chk("post_rst_end", int'(m_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
